// File: rtl/recon_gpio2_if.sv
// Avalon-MM slave bus bundle for recon_gpio2: word address, single-cycle
// write, one-cycle registered read.
interface recon_gpio2_if;
   logic [5:0]  address;
   logic        chipselect;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (output address, chipselect, read, write, writedata, input readdata);
   modport slave  (input address, chipselect, read, write, writedata, output readdata);
endinterface

// File: rtl/recon_gpio2.sv
// Reconfigurable GPIO with edge interrupts, per-pin PWM and optional input
// debounce (compiled in when RECON_GPIO2_DBNC_EN is defined).
module recon_gpio2_pin #(
   parameter int DBNC_CYCLES = 1000,
   parameter int CW          = 8
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          pin_in,
   input  logic          dbnc_ena,
   input  logic          redge,
   input  logic          fedge,
   input  logic [CW-1:0] pwm_cnt,
   input  logic [CW:0]   pwm_val,
   output logic          q,
   output logic          evt,
   output logic          pwm_out
);
   logic s1, s2, q_prev;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1      <= 1'b0;
         s2      <= 1'b0;
         q_prev  <= 1'b0;
         pwm_out <= 1'b0;
      end else begin
         s1      <= pin_in;
         s2      <= s1;
         q_prev  <= q;
         pwm_out <= ({1'b0, pwm_cnt} < pwm_val);
      end
   end

`ifdef RECON_GPIO2_DBNC_EN
   localparam int DW = (DBNC_CYCLES > 1) ? $clog2(DBNC_CYCLES) : 1;
   localparam logic [DW-1:0] DMAX = DW'(DBNC_CYCLES - 1);
   logic [DW-1:0] dcnt;

   // q only follows s2 after it has disagreed for DBNC_CYCLES consecutive cycles
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q    <= 1'b0;
         dcnt <= '0;
      end else if (!dbnc_ena || s2 == q || dcnt == DMAX) begin
         q    <= s2;
         dcnt <= '0;
      end else begin
         dcnt <= dcnt + 1'b1;
      end
   end
`else
   localparam int unused_dbnc_cycles = DBNC_CYCLES;
   logic unused_dbnc;
   assign unused_dbnc = dbnc_ena;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) q <= 1'b0;
      else          q <= s2;
   end
`endif

   assign evt = (q & ~q_prev & redge) | (~q & q_prev & fedge);
endmodule

module recon_gpio2 #(
   parameter int PORT_WIDTH     = 16,
   parameter int PWM_CNTR_WIDTH = 8,
   parameter int PWM_GROUPS     = 2,
   parameter int DBNC_CYCLES    = 1000
) (
   input  logic                  clk,
   input  logic                  reset_n,
   recon_gpio2_if.slave          bus,
   output logic                  irq,
   input  logic [PORT_WIDTH-1:0] io_in,
   output logic [PORT_WIDTH-1:0] io_out,
   output logic [PORT_WIDTH-1:0] io_oe,
   output logic [PORT_WIDTH-1:0] io_opdrn
);
   localparam int PW = PORT_WIDTH;
   localparam int CW = PWM_CNTR_WIDTH;
   localparam int G  = PWM_GROUPS;

   logic                 wr, rd;
   logic [PW-1:0]        wd, dir_r, out_r, opdrn_r, pwm_ena, irq_status;
   logic [PW-1:0]        redge, fedge, dbnc_ena, q, evt, pwm_out;
   logic [G-1:0][CW-1:0] pwm_period, pwm_cnt;
   logic [G-1:0]         per_we;
   logic [PW-1:0][CW:0]  pwm_val;
   logic [31:0]          rdata;
   logic                 unused_wd;

   assign wr        = bus.chipselect & bus.write;
   assign rd        = bus.chipselect & bus.read;
   assign wd        = bus.writedata[PW-1:0];
   assign unused_wd = ^bus.writedata;

   always_comb begin
      per_we = '0;
      for (int g = 0; g < G; g++) per_we[g] = wr && (bus.address == 6'(12 + g));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dir_r        <= '0;
         out_r        <= '0;
         opdrn_r      <= '0;
         pwm_ena      <= '0;
         redge        <= '0;
         fedge        <= '0;
         irq_status   <= '0;
         pwm_period   <= '1;
         pwm_val      <= '0;
         bus.readdata <= '0;
      end else begin
         if (wr) begin
            case (bus.address)
               6'd0:    dir_r   <= wd;
               6'd1:    out_r   <= wd;
               6'd3:    out_r   <= out_r | wd;
               6'd4:    out_r   <= out_r & ~wd;
               6'd5:    opdrn_r <= wd;
               6'd6:    pwm_ena <= wd;
               6'd9:    redge   <= wd;
               6'd10:   fedge   <= wd;
               default: ;
            endcase
         end
         for (int g = 0; g < G; g++)
            if (per_we[g]) pwm_period[g] <= bus.writedata[CW-1:0];
         for (int i = 0; i < PW; i++)
            if (wr && bus.address == 6'(16 + i)) pwm_val[i] <= bus.writedata[CW:0];
         // a new event on the same edge as its W1C keeps the bit set
         irq_status <= (irq_status & ~((wr && bus.address == 6'd7) ? wd : '0)) | evt;
         if (rd) bus.readdata <= rdata;
      end
   end

`ifdef RECON_GPIO2_DBNC_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                       dbnc_ena <= '0;
      else if (wr && bus.address == 6'd11) dbnc_ena <= wd;
   end
`else
   assign dbnc_ena = '0;
`endif

   // period write restarts the group time base on the same edge
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pwm_cnt <= '0;
      end else begin
         for (int g = 0; g < G; g++) begin
            if (per_we[g] || pwm_cnt[g] >= pwm_period[g]) pwm_cnt[g] <= '0;
            else                                          pwm_cnt[g] <= pwm_cnt[g] + 1'b1;
         end
      end
   end

   always_comb begin
      rdata = '0;
      case (bus.address)
         6'd0:    rdata[PW-1:0] = dir_r;
         6'd1:    rdata[PW-1:0] = out_r;
         6'd2:    rdata[PW-1:0] = q;
         6'd5:    rdata[PW-1:0] = opdrn_r;
         6'd6:    rdata[PW-1:0] = pwm_ena;
         6'd7:    rdata[PW-1:0] = irq_status;
         6'd8:    rdata[PW-1:0] = redge | fedge;
         6'd9:    rdata[PW-1:0] = redge;
         6'd10:   rdata[PW-1:0] = fedge;
         6'd11:   rdata[PW-1:0] = dbnc_ena;
         default: ;
      endcase
      for (int g = 0; g < G; g++)
         if (bus.address == 6'(12 + g)) rdata[CW-1:0] = pwm_period[g];
      for (int i = 0; i < PW; i++)
         if (bus.address == 6'(16 + i)) rdata[CW:0] = pwm_val[i];
   end

   for (genvar i = 0; i < PW; i++) begin : g_pin
      recon_gpio2_pin #(.DBNC_CYCLES(DBNC_CYCLES), .CW(CW)) u_pin (
         .clk      (clk),
         .reset_n  (reset_n),
         .pin_in   (io_in[i]),
         .dbnc_ena (dbnc_ena[i]),
         .redge    (redge[i]),
         .fedge    (fedge[i]),
         .pwm_cnt  (pwm_cnt[i % G]),
         .pwm_val  (pwm_val[i]),
         .q        (q[i]),
         .evt      (evt[i]),
         .pwm_out  (pwm_out[i])
      );
   end

   assign io_oe    = dir_r | pwm_ena;
   assign io_out   = (pwm_ena & pwm_out) | (~pwm_ena & out_r);
   assign io_opdrn = opdrn_r;
   assign irq      = |irq_status;
endmodule

// File: tb/tb_recon_gpio2.sv
// Bench for recon_gpio2: directed scenarios plus random traffic, every cycle
// compared against a timestamp/queue based model of the register map.
module tb_recon_gpio2;
   localparam int PW = 16, CW = 8, G = 2, DB = 4;
`ifdef RECON_GPIO2_DBNC_EN
   localparam bit DB_ON = 1'b1;
`else
   localparam bit DB_ON = 1'b0;
`endif

   logic clk = 1'b0, reset_n = 1'b0;
   logic irq;
   logic [PW-1:0] io_in, io_out, io_oe, io_opdrn;

   recon_gpio2_if bus();

   recon_gpio2 #(.PORT_WIDTH(PW), .PWM_CNTR_WIDTH(CW), .PWM_GROUPS(G), .DBNC_CYCLES(DB)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus), .irq(irq),
      .io_in(io_in), .io_out(io_out), .io_oe(io_oe), .io_opdrn(io_opdrn));

   always #5 clk = ~clk;

   int checks = 0, errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [PW-1:0] m_dir, m_out, m_opdrn, m_pena, m_stat, m_redge, m_fedge, m_dbnc;
   logic [PW-1:0] m_q, m_qp, m_pwm;
   logic [31:0]   m_rdata;
   int            m_per[G], m_start[G], m_val[PW], m_ok[PW], cyc;
   logic [PW-1:0] hist[$];

   function automatic logic [31:0] m_read(input int a);
      logic [31:0] r;
      r = '0;
      case (a)
         0:  r = 32'(m_dir);
         1:  r = 32'(m_out);
         2:  r = 32'(m_q);
         5:  r = 32'(m_opdrn);
         6:  r = 32'(m_pena);
         7:  r = 32'(m_stat);
         8:  r = 32'(m_redge | m_fedge);
         9:  r = 32'(m_redge);
         10: r = 32'(m_fedge);
         11: r = 32'(m_dbnc);
         default: begin
            if (a >= 12 && a < 12 + G)       r = 32'(m_per[a-12]);
            else if (a >= 16 && a < 16 + PW) r = 32'(m_val[a-16]);
         end
      endcase
      return r;
   endfunction

   task automatic m_reset();
      m_dir = '0; m_out = '0; m_opdrn = '0; m_pena = '0; m_stat = '0;
      m_redge = '0; m_fedge = '0; m_dbnc = '0; m_q = '0; m_qp = '0; m_pwm = '0;
      m_rdata = '0; cyc = 0;
      for (int g = 0; g < G; g++) begin m_per[g] = (1 << CW) - 1; m_start[g] = 0; end
      for (int i = 0; i < PW; i++) begin m_val[i] = 0; m_ok[i] = 0; end
      hist.delete();
      hist.push_back({PW{1'b0}});
      hist.push_back({PW{1'b0}});
   endtask

   task automatic m_step();
      logic wr, rd;
      int a;
      logic [31:0] d;
      logic [PW-1:0] sync, qn, evt, pwmn, w1c;
      int cnt[G];
      wr = bus.chipselect && bus.write;
      rd = bus.chipselect && bus.read;
      a  = int'(bus.address);
      d  = bus.writedata;
      hist.push_front(io_in);
      sync = hist[2];
      void'(hist.pop_back());
      for (int g = 0; g < G; g++) cnt[g] = (cyc - m_start[g]) % (m_per[g] + 1);
      cyc++;
      if (rd) m_rdata = m_read(a);
      for (int i = 0; i < PW; i++) begin
         pwmn[i] = (cnt[i % G] < m_val[i]);
         evt[i]  = (m_q[i] && !m_qp[i] && m_redge[i]) || (!m_q[i] && m_qp[i] && m_fedge[i]);
         if (!(DB_ON && m_dbnc[i]) || sync[i] == m_q[i] || cyc - m_ok[i] >= DB) begin
            qn[i] = sync[i];
            m_ok[i] = cyc;
         end else begin
            qn[i] = m_q[i];
         end
      end
      w1c = (wr && a == 7) ? d[PW-1:0] : '0;
      m_stat = (m_stat & ~w1c) | evt;
      if (wr) begin
         case (a)
            0:  m_dir   = d[PW-1:0];
            1:  m_out   = d[PW-1:0];
            3:  m_out   = m_out | d[PW-1:0];
            4:  m_out   = m_out & ~d[PW-1:0];
            5:  m_opdrn = d[PW-1:0];
            6:  m_pena  = d[PW-1:0];
            9:  m_redge = d[PW-1:0];
            10: m_fedge = d[PW-1:0];
            11: if (DB_ON) m_dbnc = d[PW-1:0];
            default: begin
               if (a >= 12 && a < 12 + G) begin
                  m_per[a-12]   = int'(d[CW-1:0]);
                  m_start[a-12] = cyc;
               end else if (a >= 16 && a < 16 + PW) begin
                  m_val[a-16] = int'(d[CW:0]);
               end
            end
         endcase
      end
      m_qp = m_q; m_q = qn; m_pwm = pwmn;
   endtask

   always @(posedge clk or negedge reset_n)
      if (!reset_n) m_reset();
      else          m_step();

   always @(negedge clk) begin
      chk("io_out",   32'(io_out),   32'((m_pena & m_pwm) | (~m_pena & m_out)));
      chk("io_oe",    32'(io_oe),    32'(m_dir | m_pena));
      chk("io_opdrn", 32'(io_opdrn), 32'(m_opdrn));
      chk("irq",      32'(irq),      32'(|m_stat));
      chk("readdata", bus.readdata,  m_rdata);
   end

   // ---------------- stimulus ----------------
   task automatic bwrite(input int a, input logic [31:0] d);
      bus.chipselect = 1'b1; bus.write = 1'b1; bus.read = 1'b0;
      bus.address = 6'(a); bus.writedata = d;
      @(negedge clk);
      bus.chipselect = 1'b0; bus.write = 1'b0;
   endtask

   task automatic bread(input int a, output logic [31:0] d);
      bus.chipselect = 1'b1; bus.read = 1'b1; bus.write = 1'b0; bus.address = 6'(a);
      @(negedge clk);
      d = bus.readdata;
      bus.chipselect = 1'b0; bus.read = 1'b0;
   endtask

   task automatic watch(input int len, output int rises, output int falls);
      logic prev;
      prev = 1'b0; rises = 0; falls = 0;
      bus.chipselect = 1'b1; bus.read = 1'b1; bus.write = 1'b0; bus.address = 6'd2;
      io_in[1] = 1'b1;
      for (int k = 0; k < 24; k++) begin
         if (k == len) io_in[1] = 1'b0;
         @(negedge clk);
         if (bus.readdata[1] && !prev) rises++;
         if (!bus.readdata[1] && prev) falls++;
         prev = bus.readdata[1];
      end
      bus.chipselect = 1'b0; bus.read = 1'b0;
   endtask

   task automatic count_hi(input int n, output int c0, output int c1);
      c0 = 0; c1 = 0;
      repeat (n) begin
         @(negedge clk);
         c0 += int'(io_out[0]);
         c1 += int'(io_out[1]);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] r;
      logic [9:0]  pat;
      int c0, c1, rises, falls, a, k;
      bus.chipselect = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
      bus.address = '0; bus.writedata = '0; io_in = '0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      bread(12, r); chk("period0_reset", r, 32'hFF);
      bread(13, r); chk("period1_reset", r, 32'hFF);
      bread(0, r);  chk("dir_reset", r, 32'h0);

      bwrite(0, 32'hFFFF); bwrite(1, 32'h00F0); bwrite(3, 32'h0003); bwrite(4, 32'h0010);
      bread(1, r); chk("out_set_clr", r, 32'h00E3);
      chk("io_out_set_clr", 32'(io_out), 32'h00E3);

      bwrite(9, 32'h1);
      io_in[0] = 1'b1;
      repeat (3) @(negedge clk); chk("irq_after_3_edges", 32'(irq), 32'h0);
      @(negedge clk);            chk("irq_after_4_edges", 32'(irq), 32'h1);
      io_in[0] = 1'b0;
      repeat (6) @(negedge clk);
      io_in[0] = 1'b1;
      repeat (3) @(negedge clk);
      bwrite(7, 32'h1);
      chk("irq_w1c_vs_event", 32'(irq), 32'h1);
      bread(7, r); chk("status_w1c_vs_event", r, 32'h1);
      bwrite(7, 32'h1); chk("irq_w1c", 32'(irq), 32'h0);

      bwrite(11, 32'h2);
      bread(11, r); chk("dbnc_ena_read", r, DB_ON ? 32'h2 : 32'h0);
      watch(3, rises, falls);
      chk("glitch_rises", rises, DB_ON ? 32'd0 : 32'd1);
      chk("glitch_falls", falls, DB_ON ? 32'd0 : 32'd1);
      watch(6, rises, falls);
      chk("pulse_rises", rises, 32'd1);
      chk("pulse_falls", falls, 32'd1);

      bwrite(12, 9); bwrite(13, 3); bwrite(16, 5); bwrite(17, 2); bwrite(6, 32'h3);
      repeat (3) @(negedge clk);
      count_hi(20, c0, c1);
      chk("pwm0_high_of_20", c0, 32'd10);
      chk("pwm1_high_of_20", c1, 32'd10);

      bwrite(16, 0); @(negedge clk);
      count_hi(20, c0, c1); chk("pwm0_value0", c0, 32'd0);
      bwrite(16, 10); @(negedge clk);
      count_hi(20, c0, c1); chk("pwm0_value_gt_period", c0, 32'd20);
      bwrite(16, 5); repeat (7) @(negedge clk);
      bwrite(12, 9);
      for (int j = 0; j < 10; j++) begin
         @(negedge clk);
         pat[9-j] = io_out[0];
      end
      chk("pwm_period_restart", 32'(pat), 32'(10'b1111100000));

      bwrite(5, 32'hFFFF); bwrite(10, 32'h1);
      io_in[0] = 1'b0;
      repeat (5) @(negedge clk); chk("irq_fedge", 32'(irq), 32'h1);
      bread(12, r);
      @(posedge clk); #2 reset_n = 1'b0; #1;
      chk("rst_io_out",   32'(io_out),   32'h0);
      chk("rst_io_oe",    32'(io_oe),    32'h0);
      chk("rst_io_opdrn", 32'(io_opdrn), 32'h0);
      chk("rst_irq",      32'(irq),      32'h0);
      chk("rst_readdata", bus.readdata,  32'h0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      bread(12, r); chk("period0_after_reset", r, 32'hFF);
      bread(13, r); chk("period1_after_reset", r, 32'hFF);
      repeat (5) @(negedge clk); chk("irq_after_reset", 32'(irq), 32'h0);

      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 7) == 0) begin
            k = $urandom_range(0, PW - 1);
            io_in[k] = ~io_in[k];
         end
         a = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 23);
         bus.address = 6'(a);
         if (a == 12 || a == 13)       bus.writedata = $urandom_range(0, 12);
         else if (a >= 16 && a < 32)   bus.writedata = $urandom_range(0, 14);
         else                          bus.writedata = $urandom;
         bus.chipselect = ($urandom_range(0, 3) != 0);
         bus.write      = ($urandom_range(0, 2) == 0);
         bus.read       = !bus.write && ($urandom_range(0, 1) == 1);
         @(negedge clk);
      end
      bus.chipselect = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
